// File: rtl/imm_gen_stage.sv
// imm_gen_stage: RISC-V immediate extraction + 2-entry skid buffer.
// Optional IMM_STATS_EN: saturating illegal-format counter.
//
// Ports:
//   clk, rst (sync, active-high), flush (sync squash)
//   in_valid/in_ready, instruction, ImmSrc, auto_mode : upstream side
//   out_valid/out_ready, ImmExt, out_instr, imm_err   : downstream side
//   err_count : illegal-format count (0 unless IMM_STATS_EN)
module imm_gen_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  input  logic [2:0]      ImmSrc,
  input  logic            auto_mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] ImmExt,
  output logic [31:0]     out_instr,
  output logic            imm_err,
  output logic [15:0]     err_count
);

  localparam logic [3:0] F_I    = 4'd0;
  localparam logic [3:0] F_S    = 4'd1;
  localparam logic [3:0] F_B    = 4'd2;
  localparam logic [3:0] F_J    = 4'd3;
  localparam logic [3:0] F_U    = 4'd4;
  localparam logic [3:0] F_Z    = 4'd5;
  localparam logic [3:0] F_SH   = 4'd6;
  localparam logic [3:0] F_ILL  = 4'd7;
  localparam logic [3:0] F_NONE = 4'd8;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [31:0]     ins;
    logic            err;
  } ent_t;

  logic [31:0]     w_ins;
  logic [6:0]      w_op;
  logic [2:0]      w_f3;
  logic            w_s;
  logic            w_shf3;
  logic [3:0]      w_fmt;
  logic [XLEN-1:0] w_imm;
  logic            w_err;
  ent_t            w_new;
  logic            w_push;
  logic            w_pop;

  ent_t            r_head;
  ent_t            r_tail;
  logic [1:0]      r_count;

  assign w_ins  = instruction;
  assign w_op   = w_ins[6:0];
  assign w_f3   = w_ins[14:12];
  assign w_s    = w_ins[31];
  assign w_shf3 = (w_f3 == 3'b001) || (w_f3 == 3'b101);

  always_comb begin
    w_fmt = {1'b0, ImmSrc};
    if (auto_mode) begin
      unique case (1'b1)
        (w_op == 7'b0000011),
        (w_op == 7'b1100111): w_fmt = F_I;
        (w_op == 7'b0010011):
          w_fmt = w_shf3 ? F_SH : F_I;
        (w_op == 7'b0011011):
          w_fmt = (XLEN == 64 && w_shf3) ? F_SH : F_I;
        (w_op == 7'b0100011): w_fmt = F_S;
        (w_op == 7'b1100011): w_fmt = F_B;
        (w_op == 7'b1101111): w_fmt = F_J;
        (w_op == 7'b0110111),
        (w_op == 7'b0010111): w_fmt = F_U;
        (w_op == 7'b1110011):
          w_fmt = w_f3[2] ? F_Z : F_I;
        (w_op == 7'b0110011): w_fmt = F_NONE;
        default:              w_fmt = F_ILL;
      endcase
    end
  end

  always_comb begin
    w_imm = '0;
    w_err = 1'b0;
    unique case (w_fmt)
      F_I: w_imm = {{(XLEN-12){w_s}}, w_ins[31:20]};
      F_S: w_imm = {{(XLEN-12){w_s}},
                    w_ins[31:25], w_ins[11:7]};
      F_B: w_imm = {{(XLEN-12){w_s}}, w_ins[7],
                    w_ins[30:25], w_ins[11:8], 1'b0};
      F_J: w_imm = {{(XLEN-20){w_s}}, w_ins[19:12],
                    w_ins[20], w_ins[30:21], 1'b0};
      // sign-extend the 20-bit field, then place it at bit 12
      F_U: w_imm = {{(XLEN-20){w_s}}, w_ins[31:12]} << 12;
      F_Z: w_imm = {{(XLEN-5){1'b0}}, w_ins[19:15]};
      F_SH:
        w_imm = (XLEN == 64)
              ? {{(XLEN-6){1'b0}}, w_ins[25:20]}
              : {{(XLEN-5){1'b0}}, w_ins[24:20]};
      F_ILL: w_err = 1'b1;
      default: ;
    endcase
  end

  assign w_new.imm = w_imm;
  assign w_new.ins = w_ins;
  assign w_new.err = w_err;

  assign in_ready  = (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid & in_ready & ~flush;
  assign w_pop     = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= 2'd0;
      r_head  <= '0;
      r_tail  <= '0;
    end else if (flush) begin
      r_count <= 2'd0;
    end else begin
      unique case (r_count)
        2'd0: if (w_push) begin
          r_head  <= w_new;
          r_count <= 2'd1;
        end
        2'd1: begin
          if (w_push && w_pop) begin
            r_head <= w_new;
          end else if (w_push) begin
            r_tail  <= w_new;
            r_count <= 2'd2;
          end else if (w_pop) begin
            r_count <= 2'd0;
          end
        end
        2'd2: if (w_pop) begin
          r_head  <= r_tail;
          r_count <= 2'd1;
        end
        default: r_count <= 2'd0;
      endcase
    end
  end

  assign ImmExt    = r_head.imm;
  assign out_instr = r_head.ins;
  assign imm_err   = r_head.err;

`ifdef IMM_STATS_EN
  logic [15:0] r_err_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (w_push && w_err &&
                 r_err_cnt != 16'hFFFF) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign err_count = r_err_cnt;
`else
  assign err_count = '0;
`endif

endmodule
